legv8_encoder: RTL and testbench
================================

Name: legv8_encoder

Overview:
- Streaming instruction encoder: the inverse of the main control decoder. It takes symbolic LEGv8 instructions (op enum plus register and immediate fields) over a valid/ready handshake.
- It packs each instruction into a 32-bit machine word and writes the word into instruction memory at consecutive word addresses starting at a programmable base.
- Used by the bench and boot loader to place programs into imem ahead of CPU execution.
- Supports the same eight instructions the decoder handles: ADD, SUB, AND, ORR, LDUR, STUR, CBZ, MOVZ.

Parameters:
- ADDR_W, 6, imem word-address width; address space is 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- start  in  1  begin a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first imem word address; latched on start.
- in_valid  in  1  instruction present.
- in_ready  out  1  encoder can accept an instruction.
- in_op  in  3  op enum: ADD=0, SUB=1, AND=2, ORR=3, LDUR=4, STUR=5, CBZ=6, MOVZ=7.
- in_rd  in  5  Rd (R/IW), Rt (D/CB).
- in_rn  in  5  Rn (R/D).
- in_rm  in  5  Rm (R).
- in_imm  in  19  DT_address (signed, 9-bit) / CB offset (19-bit) / MOVZ imm16.
- in_hw  in  2  MOVZ shift field.
- in_last  in  1  final instruction of the session.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse at end of session.
- count  out  ADDR_W+1  words written in the current or last session.
- err_illegal  out  1  sticky: at least one instruction was rejected.
- err_full  out  1  sticky: session ended because the address space was exhausted.

Behaviour:
- Reset (reset==0 at an edge) puts the FSM in IDLE and drives all outputs to 0 (in_ready, imem_we, imem_addr, imem_wdata, done, busy, count, err_*).
- Reset mid-session aborts it; any pending write is dropped and imem_we is 0 the following cycle.
- States:
  - IDLE: start==1 -> LOAD; latch wr_ptr=base_addr, clear count, err_illegal, err_full.
  - LOAD: in_ready=1. An accept is in_valid&&in_ready. Accept with in_last, or a legal write to address 2**ADDR_W-1 -> DONE.
  - DONE: in_ready=0, done=1 for exactly this cycle, then -> IDLE.
- start outside IDLE is ignored.
- Write latency: a legal instruction accepted in cycle N gives imem_we=1 in cycle N+1, with imem_addr=wr_ptr and the registered word. wr_ptr and count increment at the same edge.
- Back-to-back accepts yield one write per cycle.
- The write for an in_last instruction occurs in the DONE cycle. count is final when done=1.
- Encoding, fields MSB->LSB:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): op11 | Rm | shamt=000000 | Rn | Rd.
  - D-type (LDUR 11111000010, STUR 11111000000): op11 | DT_address=in_imm[8:0] | 00 | Rn | Rt.
  - CB (CBZ 10110100): op8 | in_imm[18:0] | Rt.
  - IW (MOVZ 110100101): op9 | hw | in_imm[15:0] | Rd.
- Legality checks:
  - D-type requires in_imm[18:8] to be all equal (i.e. in range -256..255).
  - MOVZ requires in_imm[18:16]==0.
  - A violating instruction is still accepted (handshake completes) but is dropped: no write, no pointer advance. err_illegal is set.
  - An illegal instruction carrying in_last still ends the session.
- Full: after the write to address 2**ADDR_W-1, the FSM enters DONE even without in_last and sets err_full.
- No wrap-around write ever occurs.
- Fields unused by an op (e.g. in_imm for R-type, in_rm for D-type) are ignored.

Decomposition:
- Package legv8_pkg:
  - op enum typedef;
  - 11/8/9-bit opcode localparams shared with the main decoder;
  - FSM state typedef.
- Sub-module legv8_word_pack: purely combinational field packer plus legality flag. The FSM, pointer and output register stay in legv8_encoder.

Test Plan:
- base_addr=0, start; ADD rd=1 rn=2 rm=3 with in_last -> imem_we at addr 0, wdata 0x8B030041; done next to that write; count=1.
- Stream SUB 1,2,3; LDUR rt=9 rn=10 imm=8; CBZ rt=5 imm=-2; MOVZ rd=4 imm=0x1234 hw=1 (last), in_valid held high -> 4 consecutive writes at addrs 0..3: 0xCB030041, 0xF8408149, 0xB4FFFFC5, 0xD2A24684.
- STUR imm=300 between two legal ops -> no write for it; err_illegal=1; addresses stay contiguous; count=2.
- ADDR_W=6, base_addr=62, three instructions without in_last -> writes at 62 and 63, then DONE with err_full=1; third is not accepted (in_ready=0).
- Assert reset (0) in LOAD the cycle after an accept -> no imem_we next cycle; all outputs 0; start afterwards works normally.
- Pulse start during LOAD with a new base_addr -> ignored; addresses continue from the current pointer.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: op enum, opcode fields, encoder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package legv8_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6,
    OP_MOVZ = 3'd7
  } op_e;

  // Opcode fields, identical to the ones the main control decoder matches on.
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/legv8_word_pack.sv
// Combinational packer: symbolic LEGv8 instruction -> 32-bit machine word + legality flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: op/rd/rn/rm/imm/hw in; word = packed instruction, legal = fields fit the format.
module legv8_word_pack
  import legv8_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] word,
  output logic        legal
);

  // D-type offset is a signed 9-bit value carried in a 19-bit field:
  // the upper bits must be a pure sign extension of bit 8.
  logic dt_in_range;
  assign dt_in_range = (&imm[18:8]) | ~(|imm[18:8]);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_e'(op))
      OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
      OP_LDUR: begin
        word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        legal = dt_in_range;
      end
      OP_STUR: begin
        word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        legal = dt_in_range;
      end
      OP_CBZ:  word = {OPC_CBZ, imm, rd};
      OP_MOVZ: begin
        word  = {OPC_MOVZ, hw, imm[15:0], rd};
        legal = (imm[18:16] == 3'b000);
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/legv8_encoder.sv
// Streaming LEGv8 encoder: packs accepted instructions and writes them to consecutive imem words.
// Latency: accept in cycle N -> imem_we in cycle N+1; one write per cycle when streaming.
// Backpressure: in_ready only in LOAD; illegal instructions are consumed but dropped.
// Ports: clk/reset (sync, active-low); start/base_addr open a session; in_* valid/ready
//        instruction stream; imem_* write port; busy/done/count/err_* status.
module legv8_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  input  logic [1:0]        in_hw,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_full
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       word;
  logic              legal;
  logic              accept;
  logic              at_top;

  legv8_word_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .hw    (in_hw),
    .word  (word),
    .legal (legal)
  );

  assign accept = in_valid && (state_q == ST_LOAD);
  // Pointer sits on the last word of the address space; a legal write here ends the session.
  assign at_top = (wr_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (in_last || (legal && at_top))) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      count       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        wr_ptr      <= base_addr;
        count       <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
      end
      if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= wr_ptr;
          imem_wdata <= word;
          // Wraps to 0 only on the top write, after which the FSM leaves LOAD.
          wr_ptr     <= wr_ptr + 1'b1;
          count      <= count + 1'b1;
          if (at_top) err_full <= 1'b1;
        end else begin
          err_illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_legv8_encoder.sv
// Self-checking bench for legv8_encoder: directed literal scenarios plus randomized traffic
// compared every cycle against a session-level behavioural model.
module tb_legv8_encoder;

  localparam int AW  = 6;
  localparam int TOP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0;
  logic [18:0]   in_imm = '0;
  logic [1:0]    in_hw = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done;
  logic [AW:0]   count;
  logic          err_illegal, err_full;

  legv8_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_hw(in_hw), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count),
    .err_illegal(err_illegal), .err_full(err_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] enc(int op, int rd, int rn, int rm, int imm, int hw);
    longint w;
    case (op)
      0: w = 64'd1112 * 2097152 + rm * 65536 + rn * 32 + rd;
      1: w = 64'd1624 * 2097152 + rm * 65536 + rn * 32 + rd;
      2: w = 64'd1104 * 2097152 + rm * 65536 + rn * 32 + rd;
      3: w = 64'd1360 * 2097152 + rm * 65536 + rn * 32 + rd;
      4: w = 64'd1986 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
      5: w = 64'd1984 * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
      6: w = 64'd180 * 16777216 + imm * 32 + rd;
      default: w = 64'd421 * 8388608 + hw * 2097152 + (imm % 65536) * 32 + rd;
    endcase
    return w[31:0];
  endfunction

  function automatic bit is_legal(int op, int imm);
    int simm;
    simm = (imm >= 262144) ? imm - 524288 : imm;
    if (op == 4 || op == 5) return (simm >= -256 && simm <= 255);
    if (op == 7) return (imm < 65536);
    return 1'b1;
  endfunction

  int phase = 0;            // 0 idle, 1 loading, 2 done
  int m_ptr = 0, m_count = 0, m_addr = 0;
  bit m_we = 0, m_ill = 0, m_full = 0;
  logic [31:0] m_data = '0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_we = 1'b0;
    if (!reset) begin
      phase = 0; m_ptr = 0; m_count = 0; m_addr = 0; m_data = '0; m_ill = 0; m_full = 0;
    end else begin
      case (phase)
        0: if (start) begin
          phase = 1; m_ptr = int'(base_addr); m_count = 0; m_ill = 0; m_full = 0;
        end
        1: if (in_valid) begin
          if (is_legal(int'(in_op), int'(in_imm))) begin
            m_we = 1'b1; m_addr = m_ptr;
            m_data = enc(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), int'(in_imm), int'(in_hw));
            m_count++;
            if (m_ptr == TOP) begin m_full = 1; phase = 2; end
            m_ptr = (m_ptr + 1) % (TOP + 1);
          end else begin
            m_ill = 1;
          end
          if (in_last) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  // ---------------- compare + capture ----------------
  typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;
  wr_t wlog[$];
  int d_cyc = -1, d_count = -1;
  bit d_ill = 0, d_full = 0;

  always @(negedge clk) begin
    chk("in_ready", in_ready, phase == 1);
    chk("busy", busy, phase != 0);
    chk("done", done, phase == 2);
    chk("imem_we", imem_we, m_we);
    chk("imem_addr", imem_addr, m_addr);
    chk("imem_wdata", imem_wdata, m_data);
    chk("count", count, m_count);
    chk("err_illegal", err_illegal, m_ill);
    chk("err_full", err_full, m_full);
    if (imem_we) wlog.push_back('{cyc, int'(imem_addr), imem_wdata});
    if (done) begin d_cyc = cyc; d_count = int'(count); d_ill = err_illegal; d_full = err_full; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_session(input int b);
    int n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("idle_wait", busy, 0);
    start = 1'b1; base_addr = b[AW-1:0];
    step();
    start = 1'b0;
  endtask

  task automatic send(input int op, input int rd, input int rn, input int rm, input int imm,
                      input int hw, input bit last, input int bound, output bit acc);
    in_valid = 1'b1; in_op = op[2:0]; in_rd = rd[4:0]; in_rn = rn[4:0]; in_rm = rm[4:0];
    in_imm = imm[18:0]; in_hw = hw[1:0]; in_last = last; acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  bit acc;

  initial begin
    // model pins
    chk("model_add", enc(0, 1, 2, 3, 0, 0), 32'h8B030041);
    chk("model_ldur", enc(4, 9, 10, 0, 8, 0), 32'hF8408149);
    chk("model_stur300_illegal", is_legal(5, 300), 0);

    step(); step();
    chk("rst_we", imem_we, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;
    step();

    // single ADD with last
    wlog.delete();
    start_session(0);
    send(0, 1, 2, 3, 0, 0, 1, 10, acc); chk("t1_acc", acc, 1);
    settle();
    chk("t1_nwr", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t1_addr", wlog[0].addr, 0);
      chk("t1_data", wlog[0].data, 32'h8B030041);
      chk("t1_done_with_write", d_cyc, wlog[0].cyc);
    end
    chk("t1_count", d_count, 1);

    // back-to-back stream
    wlog.delete();
    start_session(0);
    send(1, 1, 2, 3, 0, 0, 0, 10, acc);          chk("t2_acc0", acc, 1);
    send(4, 9, 10, 0, 8, 0, 0, 10, acc);         chk("t2_acc1", acc, 1);
    send(6, 5, 0, 0, -2, 0, 0, 10, acc);         chk("t2_acc2", acc, 1);
    send(7, 4, 0, 0, 32'h1234, 1, 1, 10, acc);   chk("t2_acc3", acc, 1);
    settle();
    chk("t2_nwr", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t2_d0", wlog[0].data, 32'hCB030041);
      chk("t2_d1", wlog[1].data, 32'hF8408149);
      chk("t2_d2", wlog[2].data, 32'hB4FFFFC5);
      chk("t2_d3", wlog[3].data, 32'hD2A24684);
      for (int i = 0; i < 4; i++) begin
        chk("t2_addr", wlog[i].addr, i);
        chk("t2_cyc", wlog[i].cyc, wlog[0].cyc + i);
      end
    end
    chk("t2_count", d_count, 4);

    // illegal STUR between two legal ops
    wlog.delete();
    start_session(20);
    send(0, 1, 2, 3, 0, 0, 0, 10, acc);     chk("t3_acc0", acc, 1);
    send(5, 7, 8, 0, 300, 0, 0, 10, acc);   chk("t3_acc1", acc, 1);
    send(1, 4, 5, 6, 0, 0, 1, 10, acc);     chk("t3_acc2", acc, 1);
    settle();
    chk("t3_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t3_a0", wlog[0].addr, 20);
      chk("t3_a1", wlog[1].addr, 21);
    end
    chk("t3_ill", d_ill, 1);
    chk("t3_count", d_count, 2);

    // address space exhaustion
    wlog.delete();
    start_session(62);
    send(0, 1, 2, 3, 0, 0, 0, 10, acc);     chk("t4_acc0", acc, 1);
    send(2, 1, 2, 3, 0, 0, 0, 10, acc);     chk("t4_acc1", acc, 1);
    send(3, 1, 2, 3, 0, 0, 0, 4, acc);      chk("t4_third_rejected", acc, 0);
    settle();
    chk("t4_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t4_a0", wlog[0].addr, 62);
      chk("t4_a1", wlog[1].addr, 63);
    end
    chk("t4_full", d_full, 1);
    chk("t4_count", d_count, 2);

    // reset in LOAD the cycle after an accept
    start_session(5);
    send(0, 1, 2, 3, 0, 0, 0, 10, acc);     chk("t5_acc", acc, 1);
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("t5_we", imem_we, 0);
    chk("t5_busy", busy, 0);
    chk("t5_count", count, 0);
    chk("t5_wdata", imem_wdata, 0);
    reset = 1'b1;
    step();
    wlog.delete();
    start_session(0);
    send(0, 1, 2, 3, 0, 0, 1, 10, acc);     chk("t5_restart_acc", acc, 1);
    settle();
    chk("t5_restart_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("t5_restart_addr", wlog[0].addr, 0);

    // start during LOAD is ignored
    wlog.delete();
    start_session(10);
    send(0, 1, 2, 3, 0, 0, 0, 10, acc);     chk("t6_acc0", acc, 1);
    in_valid = 1'b0;
    start = 1'b1; base_addr = 6'd40;
    step();
    start = 1'b0;
    send(1, 1, 2, 3, 0, 0, 1, 10, acc);     chk("t6_acc1", acc, 1);
    settle();
    chk("t6_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_a0", wlog[0].addr, 10);
      chk("t6_a1", wlog[1].addr, 11);
    end

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      int mode;
      reset     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 5) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(56, 63)) : AW'($urandom_range(0, 63));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_rd     = 5'($urandom); in_rn = 5'($urandom); in_rm = 5'($urandom);
      in_hw     = 2'($urandom);
      mode      = $urandom_range(0, 2);
      if (mode == 0)      in_imm = 19'($urandom_range(0, 600) - 300);
      else if (mode == 1) in_imm = 19'($urandom_range(0, 70000));
      else                in_imm = 19'($urandom);
      in_last   = ($urandom_range(0, 9) == 0);
      step();
    end
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
